// File: rtl/osc_multi.sv
// Purpose: N_CH independent emulated-time square-wave oscillators sharing one dt request.
// Latency: state and pulses update on each emu_clk edge; dt_req is combinational from registers only.
// Backpressure: none; the granted emu_dt is consumed every cycle. Optional macro OSC_MULTI_PHASE_EN adds the t_ph start offset input.
module osc_multi #(
    parameter int                  N_CH     = 4,
    parameter int                  DT_WIDTH = 27,
    parameter logic [DT_WIDTH-1:0] DT_MAX   = {DT_WIDTH{1'b1}}
) (
    input  logic                     emu_clk,
    input  logic                     emu_rst,
    input  logic [DT_WIDTH-1:0]      emu_dt,
    output logic [DT_WIDTH-1:0]      dt_req,
    input  logic [N_CH-1:0]          en,
    input  logic [N_CH*DT_WIDTH-1:0] t_lo,
    input  logic [N_CH*DT_WIDTH-1:0] t_hi,
`ifdef OSC_MULTI_PHASE_EN
    input  logic [N_CH*DT_WIDTH-1:0] t_ph,
`endif
    output logic [N_CH-1:0]          clk_val,
    output logic [N_CH-1:0]          rise,
    output logic [N_CH-1:0]          fall,
    output logic                     dt_err
);

    logic [N_CH-1:0]     act;
    logic [DT_WIDTH-1:0] rem [N_CH];
    logic [N_CH-1:0]     err_hit;

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        logic                act_r;
        logic                val_r;
        logic                rise_r;
        logic                fall_r;
        logic [DT_WIDTH-1:0] rem_r;
        logic [DT_WIDTH-1:0] lo_dur;
        logic [DT_WIDTH-1:0] hi_dur;
        logic [DT_WIDTH-1:0] start_dur;

        assign lo_dur = t_lo[g*DT_WIDTH +: DT_WIDTH];
        assign hi_dur = t_hi[g*DT_WIDTH +: DT_WIDTH];
`ifdef OSC_MULTI_PHASE_EN
        // First low phase after enable is the programmable phase offset.
        assign start_dur = t_ph[g*DT_WIDTH +: DT_WIDTH];
`else
        assign start_dur = lo_dur;
`endif

        // Channel state machine: disable, start, edge, or count down, in priority order.
        always_ff @(posedge emu_clk or posedge emu_rst) begin
            if (emu_rst) begin
                act_r  <= 1'b0;
                val_r  <= 1'b0;
                rem_r  <= '0;
                rise_r <= 1'b0;
                fall_r <= 1'b0;
            end else begin
                rise_r <= 1'b0;
                fall_r <= 1'b0;
                if (!en[g]) begin
                    act_r  <= 1'b0;
                    val_r  <= 1'b0;
                    rem_r  <= '0;
                    fall_r <= val_r;
                end else if (!act_r) begin
                    act_r <= 1'b1;
                    val_r <= 1'b0;
                    rem_r <= start_dur;
                end else if (emu_dt >= rem_r) begin
                    // Durations are sampled only here, so mid-period changes wait for the next reload.
                    val_r  <= ~val_r;
                    rem_r  <= val_r ? lo_dur : hi_dur;
                    rise_r <= ~val_r;
                    fall_r <= val_r;
                end else begin
                    rem_r <= rem_r - emu_dt;
                end
            end
        end

        // Overshoot only counts for a channel that is actually running this cycle.
        assign err_hit[g] = en[g] & act_r & (emu_dt > rem_r);
        assign act[g]     = act_r;
        assign rem[g]     = rem_r;
        assign clk_val[g] = val_r;
        assign rise[g]    = rise_r;
        assign fall[g]    = fall_r;
    end

    // Sticky step-overshoot flag, cleared only by reset.
    always_ff @(posedge emu_clk or posedge emu_rst) begin
        if (emu_rst) begin
            dt_err <= 1'b0;
        end else if (|err_hit) begin
            dt_err <= 1'b1;
        end
    end

    // Minimum remaining time over active channels; idle request is DT_MAX.
    always_comb begin
        logic [DT_WIDTH-1:0] min_v;
        min_v = DT_MAX;
        for (int i = 0; i < N_CH; i++) begin
            if (act[i] && (rem[i] < min_v)) begin
                min_v = rem[i];
            end
        end
        dt_req = min_v;
    end

endmodule

// File: tb/tb_osc_multi.sv
// Scoreboard bench for osc_multi with two channels and directed vectors.
// Stimulus pushes the expected post-edge state; a monitor pops and compares after each edge.
// Async reset is checked directly between edges.
module tb_osc_multi;

    localparam int          NC  = 2;
    localparam int          DW  = 27;
    localparam logic [26:0] MAX = 27'h7FF_FFFF;

    logic             emu_clk;
    logic             emu_rst;
    logic [DW-1:0]    emu_dt;
    logic [DW-1:0]    dt_req;
    logic [NC-1:0]    en;
    logic [NC*DW-1:0] t_lo;
    logic [NC*DW-1:0] t_hi;
`ifdef OSC_MULTI_PHASE_EN
    logic [NC*DW-1:0] t_ph;
`endif
    logic [NC-1:0]    clk_val;
    logic [NC-1:0]    rise;
    logic [NC-1:0]    fall;
    logic             dt_err;

    typedef struct {
        int          id;
        logic [1:0]  cv;
        logic [1:0]  rs;
        logic [1:0]  fl;
        logic [26:0] dq;
        logic        er;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   step_no = 0;

    osc_multi #(.N_CH(NC), .DT_WIDTH(DW)) dut (
        .emu_clk (emu_clk),
        .emu_rst (emu_rst),
        .emu_dt  (emu_dt),
        .dt_req  (dt_req),
        .en      (en),
        .t_lo    (t_lo),
        .t_hi    (t_hi),
`ifdef OSC_MULTI_PHASE_EN
        .t_ph    (t_ph),
`endif
        .clk_val (clk_val),
        .rise    (rise),
        .fall    (fall),
        .dt_err  (dt_err)
    );

    initial emu_clk = 1'b0;
    always #5 emu_clk = ~emu_clk;

    task automatic cmp(input string name, input int id, input int got, input int want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s step %0d: got %0d expected %0d", name, id, got, want);
        end
    endtask

    task automatic cmp_all(input exp_t e);
        cmp("clk_val", e.id, int'(clk_val), int'(e.cv));
        cmp("rise",    e.id, int'(rise),    int'(e.rs));
        cmp("fall",    e.id, int'(fall),    int'(e.fl));
        cmp("dt_req",  e.id, int'(dt_req),  int'(e.dq));
        cmp("dt_err",  e.id, int'(dt_err),  int'(e.er));
    endtask

    // Drive one cycle of inputs and queue the state expected after the following edge.
    task automatic step(input logic [1:0] e, input int dt, input logic [1:0] cv,
                        input logic [1:0] rs, input logic [1:0] fl,
                        input logic [26:0] dq, input logic er);
        exp_t x;
        @(negedge emu_clk);
        en     = e;
        emu_dt = DW'(dt);
        step_no++;
        x = '{step_no, cv, rs, fl, dq, er};
        exp_q.push_back(x);
    endtask

    task automatic set_dur(input int lo0, input int hi0, input int lo1, input int hi1);
        t_lo = {DW'(lo1), DW'(lo0)};
        t_hi = {DW'(hi1), DW'(hi0)};
`ifdef OSC_MULTI_PHASE_EN
        t_ph = t_lo;
`endif
    endtask

    // Monitor: every edge that has a queued expectation is checked 1 time unit later.
    initial begin
        exp_t e;
        forever begin
            @(posedge emu_clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                cmp_all(e);
            end
        end
    end

    initial begin
        exp_t r;
        emu_rst = 1'b1;
        en      = '0;
        emu_dt  = '0;
        set_dur(5, 3, 0, 0);
        #2;
        r = '{0, 2'b00, 2'b00, 2'b00, MAX, 1'b0};
        cmp_all(r);
        @(negedge emu_clk);
        emu_rst = 1'b0;

        // Single channel 5/3 with emu_dt = dt_req, then disable while high and re-enable.
        step(2'b01, 0, 2'b00, 2'b00, 2'b00, 5,   0);
        step(2'b01, 5, 2'b01, 2'b01, 2'b00, 3,   0);
        step(2'b01, 3, 2'b00, 2'b00, 2'b01, 5,   0);
        step(2'b01, 5, 2'b01, 2'b01, 2'b00, 3,   0);
        step(2'b01, 3, 2'b00, 2'b00, 2'b01, 5,   0);
        step(2'b01, 5, 2'b01, 2'b01, 2'b00, 3,   0);
        step(2'b00, 0, 2'b00, 2'b00, 2'b01, MAX, 0);
        step(2'b01, 0, 2'b00, 2'b00, 2'b00, 5,   0);
        step(2'b01, 2, 2'b00, 2'b00, 2'b00, 3,   0);
        step(2'b01, 3, 2'b01, 2'b01, 2'b00, 3,   0);
        step(2'b00, 0, 2'b00, 2'b00, 2'b01, MAX, 0);

        // Two channels 4/4 and 6/6: dt_req 4,2,2,4 and a simultaneous edge at t=12.
        set_dur(4, 4, 6, 6);
        step(2'b11, 0, 2'b00, 2'b00, 2'b00, 4,   0);
        step(2'b11, 4, 2'b01, 2'b01, 2'b00, 2,   0);
        step(2'b11, 2, 2'b11, 2'b10, 2'b00, 2,   0);
        step(2'b11, 2, 2'b10, 2'b00, 2'b01, 4,   0);
        step(2'b11, 4, 2'b01, 2'b01, 2'b10, 4,   0);
        step(2'b00, 0, 2'b00, 2'b00, 2'b01, MAX, 0);

        // Zero-length high phase: dt_req 0 after rise, fall on the emu_dt=0 edge, no error.
        set_dur(2, 0, 0, 0);
        step(2'b01, 0, 2'b00, 2'b00, 2'b00, 2,   0);
        step(2'b01, 2, 2'b01, 2'b01, 2'b00, 0,   0);
        step(2'b01, 0, 2'b00, 2'b00, 2'b01, 2,   0);
        step(2'b01, 2, 2'b01, 2'b01, 2'b00, 0,   0);
        step(2'b01, 0, 2'b00, 2'b00, 2'b01, 2,   0);
        step(2'b00, 0, 2'b00, 2'b00, 2'b00, MAX, 0);

        // Partial steps of 3 from 10: 10,7,4,1 then overshoot sets sticky dt_err.
        set_dur(10, 3, 0, 0);
        step(2'b01, 3,  2'b00, 2'b00, 2'b00, 10, 0);
        step(2'b01, 3,  2'b00, 2'b00, 2'b00, 7,  0);
        step(2'b01, 3,  2'b00, 2'b00, 2'b00, 4,  0);
        step(2'b01, 3,  2'b00, 2'b00, 2'b00, 1,  0);
        step(2'b01, 3,  2'b01, 2'b01, 2'b00, 3,  1);
        step(2'b01, 3,  2'b00, 2'b00, 2'b01, 10, 1);
        step(2'b01, 10, 2'b01, 2'b01, 2'b00, 3,  1);

        // Async reset between edges while clk_val, rise and dt_err are all high.
        @(posedge emu_clk);
        #3;
        emu_rst = 1'b1;
        #1;
        r = '{100, 2'b00, 2'b00, 2'b00, MAX, 1'b0};
        cmp_all(r);
        en = '0;
        @(negedge emu_clk);
        emu_rst = 1'b0;
        step(2'b01, 0, 2'b00, 2'b00, 2'b00, 10,  0);
        step(2'b00, 0, 2'b00, 2'b00, 2'b00, MAX, 0);

`ifdef OSC_MULTI_PHASE_EN
        // Phase offsets 2 and 0: ch1 toggles at t=0, ch0 at t=2.
        set_dur(4, 4, 4, 4);
        t_ph = {DW'(0), DW'(2)};
        step(2'b11, 0, 2'b00, 2'b00, 2'b00, 0, 0);
        step(2'b11, 0, 2'b10, 2'b10, 2'b00, 2, 0);
        step(2'b11, 2, 2'b11, 2'b01, 2'b00, 2, 0);
`endif

        repeat (3) @(posedge emu_clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/osc_multi.md
Name: osc_multi

Overview:
- Parametrised multi-channel successor to the single-channel emulator oscillator.
- Generates N_CH independent square-wave clock values in emulated time. Each channel has its own runtime-programmable low and high durations.
- Drives one shared timestep request, `dt_req`: the minimum remaining time to the next edge across all active channels.
- Sits beside other dt-requesting blocks. The emulator's timestep arbiter returns the granted step on `emu_dt`.

Parameters:
- N_CH, 4: number of oscillator channels (1..16).
- DT_WIDTH, 27: width of all time quantities (unsigned fixed-point, emulator dt units).
- DT_MAX, {DT_WIDTH{1'b1}}: `dt_req` value when no channel is active.

Ports:
- emu_clk  in  1  emulator clock; all state updates on rising edge.
- emu_rst  in  1  asynchronous, active-high reset.
- emu_dt  in  DT_WIDTH  granted timestep for the current cycle.
- dt_req  out  DT_WIDTH  requested timestep (min remaining time over active channels).
- en  in  N_CH  per-channel enable.
- t_lo  in  N_CH*DT_WIDTH  per-channel low duration; channel i at bits [i*DT_WIDTH +: DT_WIDTH].
- t_hi  in  N_CH*DT_WIDTH  per-channel high duration; same packing as t_lo.
- clk_val  out  N_CH  per-channel clock value.
- rise  out  N_CH  one-cycle pulse: clk_val[i] went 0->1 at this edge.
- fall  out  N_CH  one-cycle pulse: clk_val[i] went 1->0 at this edge.
- dt_err  out  1  sticky: `emu_dt` exceeded an active channel's remaining time.

Behaviour:
- Per-channel state:
  - act[i]: registered enable.
  - rem[i]: DT_WIDTH-bit remaining time to next edge.
  - val[i]: drives clk_val[i].
- Reset (async, while emu_rst=1): act=0, rem=0, val=0, rise=0, fall=0, dt_err=0. `dt_req`=DT_MAX because no channel is active.
- `dt_req` is combinational from registers only: min of rem[i] over channels with act[i]=1, else DT_MAX. No combinational path from any input to `dt_req`.
- Each emu_clk edge, per channel i, first matching rule applies:
  1. en[i]=0: act<=0, val<=0, rem<=0. If val was 1, fall[i]<=1 for one cycle.
  2. en[i]=1, act[i]=0 (start): act<=1, val<=0, rem<=t_lo[i]. Channel is excluded from `dt_req` in this cycle and included from the next.
  3. act=1, emu_dt >= rem[i] (edge): val<=~val; rem<=(~val ? t_hi[i] : t_lo[i]); rise or fall pulses accordingly. If emu_dt > rem[i], dt_err<=1.
  4. act=1, emu_dt < rem[i]: rem<=rem-emu_dt; val held.
- rise/fall are registered: high exactly one cycle, coincident with the clk_val change. Default 0.
- Durations are sampled at reload time only. Changing t_lo/t_hi mid-period does not affect the current rem.
- Zero duration: a reload of 0 gives dt_req=0 next cycle, and the channel toggles on the next edge with emu_dt=0 (zero-length phase). No stall, no error.
- Subtraction is unsigned. It is only performed when emu_dt < rem, so no wrap-around occurs.
- Simultaneous edges on several channels are legal; each toggles independently in the same cycle.
- dt_err clears only on emu_rst.
- Reset mid-period forces all outputs to their reset values immediately (asynchronous assertion).

Optional Feature:
- Macro: OSC_MULTI_PHASE_EN.
- Defined:
  - Adds input t_ph, N_CH*DT_WIDTH bits, same packing as t_lo.
  - On the start cycle (rule 2), rem<=t_ph[i] instead of t_lo[i]; val<=0.
  - Gives each channel a programmable initial phase offset.
- Undefined: port absent; start loads t_lo[i] as specified.

Test Plan:
- Single channel, N_CH=1: t_lo=5, t_hi=3, en=1, emu_dt always = dt_req.
  - dt_req sequence 5,3,5,3…; clk_val toggles every cycle after start.
  - rise on every high transition, fall on every low transition.
- Two channels: ch0 t_lo=t_hi=4, ch1 t_lo=t_hi=6, emu_dt=dt_req.
  - dt_req sequence 4,2,2,4,… (min logic).
  - ch0 edges at emulated t=4,8,12; ch1 edges at t=6,12.
  - Simultaneous toggle of both channels at t=12.
- Partial step: ch0 t_lo=10, emu_dt forced to 3 each cycle.
  - rem 10→7→4→1.
  - Next emu_dt=3 > 1: toggle, and dt_err=1 sticky.
- Disable mid-high: drop en[0] while clk_val[0]=1.
  - Next cycle clk_val[0]=0 and fall[0]=1; dt_req=DT_MAX if no other channel is active.
  - Re-enable: one start cycle, then a t_lo-long low phase.
- Zero duration: t_hi=0, t_lo=2.
  - After a rise, dt_req=0; with emu_dt=0, fall occurs next cycle.
  - No dt_err.
- Async reset mid-run: assert emu_rst between clock edges.
  - clk_val, rise, fall, dt_err go to 0 without a clock edge; dt_req=DT_MAX.
- (With OSC_MULTI_PHASE_EN) ch0 t_ph=2, ch1 t_ph=0, t_lo=t_hi=4.
  - ch1 toggles first, at t=0; ch0 first edge at t=2.
